// File: rtl/regfile_wb_buffer.sv
// Writeback buffer for the 64x32 register file: in-order FIFO of pending results, a registered
// write port draining one entry per cycle, and combinational forwarding of queued values.
module regfile_wb_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [ADDR_W-1:0]          i_in_rd,
    input  logic [DATA_W-1:0]          i_in_data,
    input  logic                       i_wb_hold,
    output logic                       o_wb_wrt,
    output logic [ADDR_W-1:0]          o_wb_rd,
    output logic [DATA_W-1:0]          o_wb_data,
    input  logic [ADDR_W-1:0]          i_fwd_rs,
    input  logic [ADDR_W-1:0]          i_fwd_rt,
    output logic                       o_fwd_rs_hit,
    output logic [DATA_W-1:0]          o_fwd_rs_data,
    output logic                       o_fwd_rt_hit,
    output logic [DATA_W-1:0]          o_fwd_rt_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [ADDR_W-1:0] r_mem_rd   [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_wb_wrt;
    logic [ADDR_W-1:0] r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;

    logic w_ready;
    logic w_accept;
    logic w_push;
    logic w_pop;

    // Ready is a pure function of state so the producer never sees a combinational path.
    assign w_ready  = (r_count < CNT_FULL);
    assign w_accept = i_in_valid & w_ready;
    assign w_push   = w_accept & (i_in_rd != '0);
    assign w_pop    = (r_count != '0) & ~i_wb_hold;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_wb_wrt  <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else begin
            r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_wb_wrt <= w_pop;
            if (w_push) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_pop) begin
                r_head    <= r_head + PTR_ONE;
                r_wb_rd   <= r_mem_rd[r_head];
                r_wb_data <= r_mem_data[r_head];
            end
        end
    end

    // Storage needs no reset: only entries inside [head, head+count) are ever read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_rd[r_tail]   <= i_in_rd;
            r_mem_data[r_tail] <= i_in_data;
        end
    end

    // Walk oldest to youngest so the youngest matching entry wins the final assignment.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx           = '0;
        o_fwd_rs_hit  = 1'b0;
        o_fwd_rs_data = '0;
        o_fwd_rt_hit  = 1'b0;
        o_fwd_rt_data = '0;
        if (r_wb_wrt && (r_wb_rd == i_fwd_rs)) begin
            o_fwd_rs_hit  = 1'b1;
            o_fwd_rs_data = r_wb_data;
        end
        if (r_wb_wrt && (r_wb_rd == i_fwd_rt)) begin
            o_fwd_rt_hit  = 1'b1;
            o_fwd_rt_data = r_wb_data;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = r_head + PTR_W'(i);
            if (CNT_W'(i) < r_count) begin
                if (r_mem_rd[idx] == i_fwd_rs) begin
                    o_fwd_rs_hit  = 1'b1;
                    o_fwd_rs_data = r_mem_data[idx];
                end
                if (r_mem_rd[idx] == i_fwd_rt) begin
                    o_fwd_rt_hit  = 1'b1;
                    o_fwd_rt_data = r_mem_data[idx];
                end
            end
        end
        if (i_fwd_rs == '0) begin
            o_fwd_rs_hit  = 1'b0;
            o_fwd_rs_data = '0;
        end
        if (i_fwd_rt == '0) begin
            o_fwd_rt_hit  = 1'b0;
            o_fwd_rt_data = '0;
        end
    end

    assign o_in_ready = w_ready;
    assign o_wb_wrt   = r_wb_wrt;
    assign o_wb_rd    = r_wb_rd;
    assign o_wb_data  = r_wb_data;
    assign o_count    = r_count;

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Self-checking bench for regfile_wb_buffer: hand-derived vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_regfile_wb_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_rd;
    logic [31:0] in_data;
    logic        wb_hold;
    logic        wb_wrt;
    logic [5:0]  wb_rd;
    logic [31:0] wb_data;
    logic [5:0]  fwd_rs;
    logic [5:0]  fwd_rt;
    logic        fwd_rs_hit;
    logic [31:0] fwd_rs_data;
    logic        fwd_rt_hit;
    logic [31:0] fwd_rt_data;
    logic [2:0]  count;

    regfile_wb_buffer #(.DEPTH(DEPTH), .ADDR_W(6), .DATA_W(32)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_rd       (in_rd),
        .i_in_data     (in_data),
        .i_wb_hold     (wb_hold),
        .o_wb_wrt      (wb_wrt),
        .o_wb_rd       (wb_rd),
        .o_wb_data     (wb_data),
        .i_fwd_rs      (fwd_rs),
        .i_fwd_rt      (fwd_rt),
        .o_fwd_rs_hit  (fwd_rs_hit),
        .o_fwd_rs_data (fwd_rs_data),
        .o_fwd_rt_hit  (fwd_rt_hit),
        .o_fwd_rt_data (fwd_rt_data),
        .o_count       (count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending results as a queue, plus the write-port register.
    typedef struct packed {
        logic [5:0]  rd;
        logic [31:0] data;
    } entry_t;
    entry_t      q[$];
    logic        m_wrt;
    logic [5:0]  m_rd;
    logic [31:0] m_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_fwd(input logic [5:0] a, output logic hit,
                                      output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (a == 6'd0) return;
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].rd == a) begin
                hit = 1'b1;
                d   = q[k].data;
                return;
            end
        end
        if (m_wrt && m_rd == a) begin
            hit = 1'b1;
            d   = m_data;
        end
    endfunction

    task automatic model_reset();
        q.delete();
        m_wrt  = 1'b0;
        m_rd   = '0;
        m_data = '0;
    endtask

    // One clock edge: the model decides push/pop from pre-edge state and inputs.
    task automatic tick();
        logic   acc;
        logic   pop;
        entry_t e;
        acc = in_valid && (q.size() < DEPTH);
        pop = (q.size() > 0) && !wb_hold;
        @(posedge clk);
        m_wrt = pop;
        if (pop) begin
            e      = q.pop_front();
            m_rd   = e.rd;
            m_data = e.data;
        end
        if (acc && in_rd != 6'd0) q.push_back('{rd: in_rd, data: in_data});
        #1;
    endtask

    task automatic check_all(input string tag);
        logic        h;
        logic [31:0] d;
        chk({tag, "_count"}, 64'(count), 64'(q.size()));
        chk({tag, "_ready"}, 64'(in_ready), 64'(q.size() < DEPTH));
        chk({tag, "_wrt"}, 64'(wb_wrt), 64'(m_wrt));
        chk({tag, "_rd"}, 64'(wb_rd), 64'(m_rd));
        chk({tag, "_data"}, 64'(wb_data), 64'(m_data));
        model_fwd(fwd_rs, h, d);
        chk({tag, "_rs_hit"}, 64'(fwd_rs_hit), 64'(h));
        chk({tag, "_rs_data"}, 64'(fwd_rs_data), 64'(d));
        model_fwd(fwd_rt, h, d);
        chk({tag, "_rt_hit"}, 64'(fwd_rt_hit), 64'(h));
        chk({tag, "_rt_data"}, 64'(fwd_rt_data), 64'(d));
    endtask

    task automatic drive(input logic v, input logic [5:0] rd, input logic [31:0] d,
                         input logic hold, input logic [5:0] rs, input logic [5:0] rt);
        in_valid = v;
        in_rd    = rd;
        in_data  = d;
        wb_hold  = hold;
        fwd_rs   = rs;
        fwd_rt   = rt;
    endtask

    typedef struct {
        logic        v;
        logic [5:0]  rd;
        logic [31:0] d;
        logic        hold;
        logic [5:0]  rs;
        logic        e_wrt;
        logic [5:0]  e_rd;
        logic [31:0] e_data;
        int          e_cnt;
        logic        e_ready;
        logic        e_hit;
        logic [31:0] e_hdata;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // Single push, retire, idle; then fill under hold, overflow attempt, drain in order.
        tbl[0]  = '{1'b1, 6'd7, 32'h2,  1'b0, 6'd7, 1'b0, 6'd0, 32'h0,  1, 1'b1, 1'b1, 32'h2};
        tbl[1]  = '{1'b0, 6'd0, 32'h0,  1'b0, 6'd7, 1'b1, 6'd7, 32'h2,  0, 1'b1, 1'b1, 32'h2};
        tbl[2]  = '{1'b0, 6'd0, 32'h0,  1'b0, 6'd7, 1'b0, 6'd7, 32'h2,  0, 1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 6'd1, 32'h10, 1'b1, 6'd1, 1'b0, 6'd7, 32'h2,  1, 1'b1, 1'b1, 32'h10};
        tbl[4]  = '{1'b1, 6'd2, 32'h20, 1'b1, 6'd2, 1'b0, 6'd7, 32'h2,  2, 1'b1, 1'b1, 32'h20};
        tbl[5]  = '{1'b1, 6'd3, 32'h30, 1'b1, 6'd3, 1'b0, 6'd7, 32'h2,  3, 1'b1, 1'b1, 32'h30};
        tbl[6]  = '{1'b1, 6'd4, 32'h40, 1'b1, 6'd4, 1'b0, 6'd7, 32'h2,  4, 1'b0, 1'b1, 32'h40};
        tbl[7]  = '{1'b1, 6'd5, 32'h50, 1'b1, 6'd5, 1'b0, 6'd7, 32'h2,  4, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 6'd5, 32'h50, 1'b0, 6'd1, 1'b1, 6'd1, 32'h10, 3, 1'b1, 1'b1, 32'h10};
        tbl[9]  = '{1'b1, 6'd5, 32'h50, 1'b0, 6'd5, 1'b1, 6'd2, 32'h20, 3, 1'b1, 1'b1, 32'h50};
        tbl[10] = '{1'b0, 6'd0, 32'h0,  1'b0, 6'd2, 1'b1, 6'd3, 32'h30, 2, 1'b1, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 6'd0, 32'h0,  1'b0, 6'd4, 1'b1, 6'd4, 32'h40, 1, 1'b1, 1'b1, 32'h40};
        tbl[12] = '{1'b0, 6'd0, 32'h0,  1'b0, 6'd5, 1'b1, 6'd5, 32'h50, 0, 1'b1, 1'b1, 32'h50};
        tbl[13] = '{1'b0, 6'd0, 32'h0,  1'b0, 6'd5, 1'b0, 6'd5, 32'h50, 0, 1'b1, 1'b0, 32'h0};

        rst_n = 1'b0;
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd7, 6'd11);
        model_reset();
        #3;
        chk("rst_wrt", 64'(wb_wrt), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        #19 rst_n = 1'b1;
        tick();
        tick();
        check_all("idle");
        chk("idle_ready", 64'(in_ready), 64'd1);
        chk("idle_rs_hit", 64'(fwd_rs_hit), 64'd0);
        chk("idle_rt_hit", 64'(fwd_rt_hit), 64'd0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].rd, tbl[i].d, tbl[i].hold, tbl[i].rs, 6'd0);
            tick();
            chk($sformatf("vec%0d_wrt", i), 64'(wb_wrt), 64'(tbl[i].e_wrt));
            chk($sformatf("vec%0d_rd", i), 64'(wb_rd), 64'(tbl[i].e_rd));
            chk($sformatf("vec%0d_data", i), 64'(wb_data), 64'(tbl[i].e_data));
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_ready", i), 64'(in_ready), 64'(tbl[i].e_ready));
            chk($sformatf("vec%0d_hit", i), 64'(fwd_rs_hit), 64'(tbl[i].e_hit));
            chk($sformatf("vec%0d_hdata", i), 64'(fwd_rs_data), 64'(tbl[i].e_hdata));
        end

        // Youngest-wins forwarding and dropped r0 writes.
        drive(1'b1, 6'd11, 32'h5, 1'b1, 6'd0, 6'd11);
        tick();
        drive(1'b1, 6'd11, 32'h9, 1'b1, 6'd0, 6'd11);
        tick();
        chk("young_rt_hit", 64'(fwd_rt_hit), 64'd1);
        chk("young_rt_data", 64'(fwd_rt_data), 64'h9);
        chk("r0_rs_hit", 64'(fwd_rs_hit), 64'd0);
        drive(1'b1, 6'd0, 32'hFFFF, 1'b1, 6'd0, 6'd11);
        tick();
        chk("r0_count", 64'(count), 64'd2);
        check_all("r0");
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd11, 6'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_all("r0_drain");
            if (wb_wrt) chk("r0_never_written", 64'(wb_rd != 6'd0), 64'd1);
        end

        // Asynchronous reset mid-stream discards queued entries.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'(20 + i), 32'(100 + i), 1'b1, 6'd20, 6'd0);
            tick();
        end
        chk("pre_rst_count", 64'(count), 64'd3);
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd20, 6'd21);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #2 rst_n = 1'b1;
        tick();
        check_all("post_rst_idle");
        chk("post_rst_no_write", 64'(wb_wrt), 64'd0);
        drive(1'b1, 6'd2, 32'hA, 1'b0, 6'd2, 6'd0);
        tick();
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd2, 6'd0);
        tick();
        chk("post_rst_wrt", 64'(wb_wrt), 64'd1);
        chk("post_rst_rd", 64'(wb_rd), 64'd2);
        chk("post_rst_data", 64'(wb_data), 64'hA);
        tick();
        check_all("post_rst_done");

        // Full-rate stream never fills and retires every cycle once primed.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 6'(1 + (i % 31)), 32'hC000 + 32'(i), 1'b0, 6'(1 + (i % 31)), 6'd0);
            chk("stream_ready", 64'(in_ready), 64'd1);
            tick();
            if (i > 0) chk("stream_wrt", 64'(wb_wrt), 64'd1);
            chk("stream_cnt_le1", 64'(count <= 3'd1), 64'd1);
            check_all("stream");
        end
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 6'd0);
        tick();
        chk("stream_last_rd", 64'(wb_rd), 64'd20);
        chk("stream_last_data", 64'(wb_data), 64'hC013);
        tick();
        check_all("stream_end");

        // Randomized traffic against the model; small address range forces collisions.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(3) != 0), 6'($urandom_range(7)), $urandom,
                  ($urandom_range(3) == 0), 6'($urandom_range(7)), 6'($urandom_range(7)));
            #1;
            check_all("rnd_pre");
            tick();
            check_all("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
